// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM stage of a five-stage MIPS pipeline.
//                - EXE/MEM pipeline register capturing the EX stage results.
//                - Word-wide data RAM (2^ADDR_W x 32 bits).
//                  Reads are asynchronous. Writes are synchronous.
//                - Conditional branch resolution (taken flag and target PC).
//                - MEM-side forwarding value (mem_aluR) returned to EX.
//                - Load data, ALU result, destination and control to WB.
//
//  Parameters  : ADDR_W  word-address width of the data RAM
//
//  Ports       : clk, rst_n                  clock, async active-low reset
//                ex_wreg/ex_m2reg/ex_wmem    control from EX
//                ex_branch/ex_zero           branch qualifier and ALU zero
//                ex_aluR/ex_inB/ex_pc        ALU result, store data, target
//                ex_destR                    destination register number
//                EXE_ins_type/EXE_ins_number debug tags from EX
//                ex_flush                    load a bubble this edge
//                mem_wreg/mem_m2reg          registered control to WB
//                mem_aluR                    registered ALU result/forwarding
//                mem_mo                      RAM read data at mem_aluR
//                mem_destR                   registered destination
//                mem_pcsrc/mem_branch_pc     branch taken and its target
//                MEM_ins_type/MEM_ins_number registered debug tags
//                mem_misalign                misaligned access flag
//
//  Build option: MEM_ALIGN_CHECK_EN
//                Defined   : a load or store whose address is not word
//                            aligned raises mem_misalign. The store is
//                            dropped and the load data reads as zero.
//                Undefined : mem_misalign is tied low. The low two address
//                            bits are ignored, so the access is word-truncated.
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage #(
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        ex_wmem,
  input  logic        ex_branch,
  input  logic        ex_zero,
  input  logic [31:0] ex_aluR,
  input  logic [31:0] ex_inB,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_destR,
  input  logic [3:0]  EXE_ins_type,
  input  logic [3:0]  EXE_ins_number,
  input  logic        ex_flush,
  output logic        mem_wreg,
  output logic        mem_m2reg,
  output logic [31:0] mem_aluR,
  output logic [31:0] mem_mo,
  output logic [4:0]  mem_destR,
  output logic        mem_pcsrc,
  output logic [31:0] mem_branch_pc,
  output logic [3:0]  MEM_ins_type,
  output logic [3:0]  MEM_ins_number,
  output logic        mem_misalign
);

  localparam int c_ram_depth = 1 << ADDR_W;

  // --------------------------------------------------------------------------
  // EXE/MEM pipeline register
  // --------------------------------------------------------------------------
  logic        r_wreg;
  logic        r_m2reg;
  logic        r_wmem;
  logic        r_branch;
  logic        r_zero;
  logic [31:0] r_alu_r;
  logic [31:0] r_store_data;
  logic [31:0] r_branch_pc;
  logic [4:0]  r_dest_r;
  logic [3:0]  r_ins_type;
  logic [3:0]  r_ins_number;

  // The reset is asynchronous. When it is asserted during a store, r_wmem
  // clears at once, so the store cannot reach the RAM at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wreg       <= 1'b0;
      r_m2reg      <= 1'b0;
      r_wmem       <= 1'b0;
      r_branch     <= 1'b0;
      r_zero       <= 1'b0;
      r_alu_r      <= 32'd0;
      r_store_data <= 32'd0;
      r_branch_pc  <= 32'd0;
      r_dest_r     <= 5'd0;
      r_ins_type   <= 4'd0;
      r_ins_number <= 4'd0;
    end else begin
      // A flush kills every side effect of the slot. The data fields still
      // load because, with the controls cleared, nothing consumes them.
      if (ex_flush) begin
        r_wreg   <= 1'b0;
        r_m2reg  <= 1'b0;
        r_wmem   <= 1'b0;
        r_branch <= 1'b0;
      end else begin
        r_wreg   <= ex_wreg;
        r_m2reg  <= ex_m2reg;
        r_wmem   <= ex_wmem;
        r_branch <= ex_branch;
      end
      r_zero       <= ex_zero;
      r_alu_r      <= ex_aluR;
      r_store_data <= ex_inB;
      r_branch_pc  <= ex_pc;
      r_dest_r     <= ex_destR;
      r_ins_type   <= EXE_ins_type;
      r_ins_number <= EXE_ins_number;
    end
  end

  // --------------------------------------------------------------------------
  // Alignment qualification
  // --------------------------------------------------------------------------
  logic w_misalign;

`ifdef MEM_ALIGN_CHECK_EN
  // Only real memory accesses are checked. A plain ALU result with nonzero
  // low bits is legal.
  assign w_misalign = (r_wmem | r_m2reg) & (r_alu_r[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Data RAM
  // --------------------------------------------------------------------------
  // The address bits above ADDR_W+1 are dropped, so the address space wraps
  // modulo the RAM size.
  logic [ADDR_W-1:0] w_word_addr;
  logic              w_ram_we;
  logic [31:0]       w_ram_rdata;
  logic [31:0]       r_ram [c_ram_depth];

  assign w_word_addr = r_alu_r[ADDR_W+1:2];
  assign w_ram_we    = r_wmem & ~w_misalign;
  assign w_ram_rdata = r_ram[w_word_addr];

  // The array has no reset. Its contents are undefined until written.
  // The write takes effect at the edge that ends the MEM cycle, so a load
  // that follows a store to the same word reads the new value.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_word_addr] <= r_store_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_wreg       = r_wreg;
  assign mem_m2reg      = r_m2reg;
  assign mem_aluR       = r_alu_r;
  assign mem_mo         = w_misalign ? 32'd0 : w_ram_rdata;
  assign mem_destR      = r_dest_r;
  // r_branch is cleared on a flush, so a flushed slot never redirects the PC.
  assign mem_pcsrc      = r_branch & r_zero;
  assign mem_branch_pc  = r_branch_pc;
  assign MEM_ins_type   = r_ins_type;
  assign MEM_ins_number = r_ins_number;
  assign mem_misalign   = w_misalign;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Scoreboard testbench for mem_stage. The driver issues one
//                instruction per cycle and queues the expected MEM-cycle
//                response. The monitor pops and compares one entry after
//                each rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero, ex_flush;
  logic [31:0] ex_aluR, ex_inB, ex_pc;
  logic [4:0]  ex_destR;
  logic [3:0]  EXE_ins_type, EXE_ins_number;
  logic        mem_wreg, mem_m2reg, mem_pcsrc, mem_misalign;
  logic [31:0] mem_aluR, mem_mo, mem_branch_pc;
  logic [4:0]  mem_destR;
  logic [3:0]  MEM_ins_type, MEM_ins_number;

  mem_stage #(.ADDR_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_wreg        (ex_wreg),
    .ex_m2reg       (ex_m2reg),
    .ex_wmem        (ex_wmem),
    .ex_branch      (ex_branch),
    .ex_zero        (ex_zero),
    .ex_aluR        (ex_aluR),
    .ex_inB         (ex_inB),
    .ex_pc          (ex_pc),
    .ex_destR       (ex_destR),
    .EXE_ins_type   (EXE_ins_type),
    .EXE_ins_number (EXE_ins_number),
    .ex_flush       (ex_flush),
    .mem_wreg       (mem_wreg),
    .mem_m2reg      (mem_m2reg),
    .mem_aluR       (mem_aluR),
    .mem_mo         (mem_mo),
    .mem_destR      (mem_destR),
    .mem_pcsrc      (mem_pcsrc),
    .mem_branch_pc  (mem_branch_pc),
    .MEM_ins_type   (MEM_ins_type),
    .MEM_ins_number (MEM_ins_number),
    .mem_misalign   (mem_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        wreg;
    logic        m2reg;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        pcsrc;
    logic [31:0] bpc;
    logic [3:0]  typ;
    logic [3:0]  num;
    logic        chk_data;
    logic        chk_mo;
    logic [31:0] mo;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   vec_id  = 0;

  task automatic check(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (vec %0d): got 0x%08h, expected 0x%08h", nm, id, act, exp);
  endtask

  task automatic set_idle();
    ex_wreg = 0; ex_m2reg = 0; ex_wmem = 0; ex_branch = 0; ex_zero = 0;
    ex_flush = 0; ex_aluR = 0; ex_inB = 0; ex_pc = 0; ex_destR = 0;
    EXE_ins_type = 0; EXE_ins_number = 0;
  endtask

  // Drive one instruction and queue the response expected in its MEM cycle.
  task automatic issue(input logic wreg, input logic m2reg, input logic wmem,
                       input logic branch, input logic zero, input logic flush,
                       input logic [31:0] alu, input logic [31:0] inb,
                       input logic [31:0] pc, input logic [4:0] dest,
                       input logic exp_pcsrc, input logic chk_mo,
                       input logic [31:0] exp_mo, input logic exp_mis);
    exp_t e;
    @(negedge clk);
    vec_id++;
    ex_wreg = wreg; ex_m2reg = m2reg; ex_wmem = wmem; ex_branch = branch;
    ex_zero = zero; ex_flush = flush; ex_aluR = alu; ex_inB = inb;
    ex_pc = pc; ex_destR = dest;
    EXE_ins_type = 4'(vec_id); EXE_ins_number = 4'(vec_id + 3);
    e.id = vec_id;
    e.wreg = flush ? 1'b0 : wreg;
    e.m2reg = flush ? 1'b0 : m2reg;
    e.alu = alu; e.dest = dest; e.pcsrc = exp_pcsrc; e.bpc = pc;
    e.typ = 4'(vec_id); e.num = 4'(vec_id + 3);
    e.chk_data = !flush; e.chk_mo = chk_mo; e.mo = exp_mo; e.mis = exp_mis;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drain", vec_id, 32'(q.size()), 32'd0);
  endtask

  // Monitor: one MEM-cycle response per rising edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        check("mem_wreg",  e.id, 32'(mem_wreg),  32'(e.wreg));
        check("mem_m2reg", e.id, 32'(mem_m2reg), 32'(e.m2reg));
        check("mem_pcsrc", e.id, 32'(mem_pcsrc), 32'(e.pcsrc));
        check("mem_misalign", e.id, 32'(mem_misalign), 32'(e.mis));
        if (e.chk_data) begin
          check("mem_aluR",       e.id, mem_aluR,            e.alu);
          check("mem_destR",      e.id, 32'(mem_destR),      32'(e.dest));
          check("mem_branch_pc",  e.id, mem_branch_pc,       e.bpc);
          check("MEM_ins_type",   e.id, 32'(MEM_ins_type),   32'(e.typ));
          check("MEM_ins_number", e.id, 32'(MEM_ins_number), 32'(e.num));
        end
        if (e.chk_mo) check("mem_mo", e.id, mem_mo, e.mo);
      end
    end
  end

  localparam logic c_align = `ifdef MEM_ALIGN_CHECK_EN 1'b1 `else 1'b0 `endif;

  initial begin
    set_idle();
    rst_n = 1'b0;
    #1;
    check("reset_wreg",   0, 32'(mem_wreg),       32'd0);
    check("reset_m2reg",  0, 32'(mem_m2reg),      32'd0);
    check("reset_pcsrc",  0, 32'(mem_pcsrc),      32'd0);
    check("reset_aluR",   0, mem_aluR,            32'd0);
    check("reset_bpc",    0, mem_branch_pc,       32'd0);
    check("reset_destR",  0, 32'(mem_destR),      32'd0);
    check("reset_type",   0, 32'(MEM_ins_type),   32'd0);
    check("reset_number", 0, 32'(MEM_ins_number), 32'd0);
    check("reset_misal",  0, 32'(mem_misalign),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //     wreg m2r wmem br z fl  aluR          inB           pc     dest pcs chkmo mo            mis
    issue(0, 0, 1, 0, 0, 0, 32'h0000_0020, 32'h0000_1234, 32'h0,  5'd0, 0, 0, 32'h0,         0);
    issue(0, 0, 1, 0, 0, 0, 32'h0000_0014, 32'h0000_5555, 32'h0,  5'd0, 0, 0, 32'h0,         0);
    issue(0, 0, 1, 0, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,  5'd0, 0, 0, 32'h0,         0);
    // Back-to-back load of the word stored on the previous cycle.
    issue(1, 1, 0, 0, 0, 0, 32'h0000_0010, 32'h0,         32'h0,  5'd3, 0, 1, 32'hDEAD_BEEF, 0);
    // Branch taken, then not taken.
    issue(0, 0, 0, 1, 1, 0, 32'h0,         32'h0,         32'h40, 5'd0, 1, 0, 32'h0,         0);
    issue(0, 0, 0, 1, 0, 0, 32'h0,         32'h0,         32'h40, 5'd0, 0, 0, 32'h0,         0);
    // Flushed store plus a flushed taken branch: no write, no redirect.
    issue(1, 0, 1, 1, 1, 1, 32'h0000_0020, 32'h0000_0005, 32'h44, 5'd9, 0, 0, 32'h0,         0);
    issue(1, 1, 0, 0, 0, 0, 32'h0000_0020, 32'h0,         32'h0,  5'd4, 0, 1, 32'h0000_1234, 0);
    // Address wrap: 0x104 aliases word 1, which is address 0x4.
    issue(0, 0, 1, 0, 0, 0, 32'h0000_0104, 32'h0000_0077, 32'h0,  5'd0, 0, 0, 32'h0,         0);
    issue(1, 1, 0, 0, 0, 0, 32'h0000_0004, 32'h0,         32'h0,  5'd5, 0, 1, 32'h0000_0077, 0);
    // A plain ALU result with nonzero low bits is never flagged.
    issue(1, 0, 0, 0, 0, 0, 32'h0000_0013, 32'h0,         32'h0,  5'd7, 0, 0, 32'h0,         0);
    // Misaligned store into word 4, then aligned and misaligned loads of it.
    issue(0, 0, 1, 0, 0, 0, 32'h0000_0012, 32'h0000_CAFE, 32'h0,  5'd0, 0, 0, 32'h0,         c_align);
    issue(1, 1, 0, 0, 0, 0, 32'h0000_0010, 32'h0,         32'h0,  5'd6, 0, 1,
          c_align ? 32'hDEAD_BEEF : 32'h0000_CAFE, 0);
    issue(1, 1, 0, 0, 0, 0, 32'h0000_0012, 32'h0,         32'h0,  5'd6, 0, 1,
          c_align ? 32'h0 : 32'h0000_CAFE, c_align);
    // A store that an asynchronous reset interrupts during its MEM cycle.
    issue(1, 0, 1, 1, 1, 0, 32'h0000_0014, 32'h0000_AAAA, 32'h80, 5'd2, 1, 0, 32'h0,         0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    set_idle();
    #1;
    check("async_reset_wreg",  vec_id, 32'(mem_wreg),  32'd0);
    check("async_reset_pcsrc", vec_id, 32'(mem_pcsrc), 32'd0);
    check("async_reset_aluR",  vec_id, mem_aluR,       32'd0);
    check("async_reset_bpc",   vec_id, mem_branch_pc,  32'd0);
    check("async_reset_destR", vec_id, 32'(mem_destR), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Word 5 must still hold its value from before the interrupted store.
    issue(1, 1, 0, 0, 0, 0, 32'h0000_0014, 32'h0,         32'h0,  5'd8, 0, 1, 32'h0000_5555, 0);
    @(negedge clk);
    set_idle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
